i2c_write_sequencer: RTL and testbench

I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

---
 rtl/i2c_write_sequencer_if.sv | 29 ++
 rtl/i2c_write_sequencer.sv | 175 +++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_sequencer_if.sv
// Bus bundle between the write sequencer, its upstream byte source and the
// byte-level I2C engine. The sequencer uses the slave modport.
interface i2c_write_sequencer_if;
    logic       txStart;
    logic [6:0] txAddr;
    logic [7:0] txCtrl;
    logic [4:0] txLen;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady;
    logic [1:0] instruction;
    logic       enable;
    logic [7:0] byteToSend;
    logic       complete;
    logic       error;
    logic       busy;
    logic       done;
    logic       nack;

    modport master (
        output txStart, txAddr, txCtrl, txLen, dataIn, dataValid, complete, error,
        input  dataReady, instruction, enable, byteToSend, busy, done, nack
    );

    modport slave (
        input  txStart, txAddr, txCtrl, txLen, dataIn, dataValid, complete, error,
        output dataReady, instruction, enable, byteToSend, busy, done, nack
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// I2C write sequencer: issues START, address, control byte, payload bytes
// and STOP to a byte-level engine, with an idle gap after every instruction.
// GAP_CYCLES must be at least 2.
module i2c_write_sequencer #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_write_sequencer_if.slave  bus
);

    localparam logic [1:0]  OP_START = 2'd0;
    localparam logic [1:0]  OP_STOP  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd3;
    localparam int unsigned GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_CTRL, S_FETCH, S_DATA, S_STOP, S_GAP
    } state_t;

    state_t        r_state, w_state_nx;
    state_t        r_ret, w_ret_nx;
    logic [GW-1:0] r_gap;
    logic [6:0]    r_addr;
    logic [7:0]    r_ctrl;
    logic [7:0]    r_data;
    logic [4:0]    r_remain;
    logic          r_nack;

    logic          w_accept, w_pop, w_enter_gap, w_set_nack;
    logic          w_enable, w_ready, w_done;
    logic [1:0]    w_instr;
    logic [7:0]    w_byte;

    // State register and return target taken after the current gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
            r_ret   <= w_ret_nx;
        end
    end

    // Next-state decode and engine/upstream outputs
    always_comb begin
        w_state_nx  = r_state;
        w_ret_nx    = r_ret;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        w_enter_gap = 1'b0;
        w_set_nack  = 1'b0;
        w_enable    = 1'b0;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_instr     = OP_START;
        w_byte      = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.txStart) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_enable = 1'b1;
                w_instr  = OP_START;
                if (bus.complete) begin
                    w_enter_gap = 1'b1;
                    w_ret_nx    = S_ADDR;
                end
            end
            S_ADDR: begin
                w_enable = 1'b1;
                w_instr  = OP_WRITE;
                w_byte   = {r_addr, 1'b0};
                if (bus.complete) begin
                    w_enter_gap = 1'b1;
                    w_set_nack  = bus.error;
                    w_ret_nx    = bus.error ? S_STOP : S_CTRL;
                end
            end
            S_CTRL: begin
                w_enable = 1'b1;
                w_instr  = OP_WRITE;
                w_byte   = r_ctrl;
                if (bus.complete) begin
                    w_enter_gap = 1'b1;
                    w_set_nack  = bus.error;
                    w_ret_nx    = (bus.error || r_remain == '0) ? S_STOP : S_FETCH;
                end
            end
            S_FETCH: begin
                w_ready = 1'b1;
                if (bus.dataValid) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                w_enable = 1'b1;
                w_instr  = OP_WRITE;
                w_byte   = r_data;
                if (bus.complete) begin
                    w_enter_gap = 1'b1;
                    w_set_nack  = bus.error;
                    w_ret_nx    = (bus.error || r_remain == '0) ? S_STOP : S_FETCH;
                end
            end
            S_STOP: begin
                w_enable = 1'b1;
                w_instr  = OP_STOP;
                if (bus.complete) begin
                    w_enter_gap = 1'b1;
                    w_ret_nx    = S_IDLE;
                end
            end
            S_GAP: begin
                // Only the gap following STOP returns to IDLE, so done is
                // raised on exactly that last gap cycle while still busy.
                if (r_gap == '0) begin
                    w_state_nx = r_ret;
                    w_done     = (r_ret == S_IDLE);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_enter_gap) begin
            w_state_nx = S_GAP;
        end
    end

    // Gap timer, latched transaction fields, payload byte and NACK flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap    <= '0;
            r_addr   <= '0;
            r_ctrl   <= '0;
            r_data   <= '0;
            r_remain <= '0;
            r_nack   <= 1'b0;
        end else begin
            if (w_enter_gap) begin
                r_gap <= GW'(GAP_CYCLES - 1);
            end else if (r_state == S_GAP && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            if (w_accept) begin
                r_addr   <= bus.txAddr;
                r_ctrl   <= bus.txCtrl;
                r_remain <= bus.txLen;
                r_nack   <= 1'b0;
            end
            if (w_pop) begin
                r_data <= bus.dataIn;
                if (r_remain != '0) begin
                    r_remain <= r_remain - 1'b1;
                end
            end
            if (w_set_nack) begin
                r_nack <= 1'b1;
            end
        end
    end

    assign bus.enable      = w_enable;
    assign bus.instruction = w_instr;
    assign bus.byteToSend  = w_byte;
    assign bus.dataReady   = w_ready;
    assign bus.done        = w_done;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.nack        = r_nack;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Self-checking bench for i2c_write_sequencer: table-driven transactions,
// hand-written stall/reset sequences and randomized transactions, all
// compared against a transaction-level model of the expected engine traffic.
module tb_i2c_write_sequencer;

    localparam int GAP = 2;

    logic clk;
    logic rst;
    i2c_write_sequencer_if bus ();

    i2c_write_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Upstream source, engine model and observation state
    logic [7:0] src_q[$];
    logic [7:0] data_q[$];
    logic [1:0] got_i[$];
    logic [7:0] got_b[$];
    logic [1:0] exp_i[$];
    logic [7:0] exp_b[$];
    int  m_pops;
    bit  m_nack;
    int  pops, done_cnt, viol, op_idx, err_op_cur, lat_max, valid_pct;
    int  eng_cnt, eng_lat, low_run;
    bit  ready_seen, done_nack, hold_valid;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] ctrl;
        logic [4:0] len;
        int         err_op;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         poke;
        int         exp_ops;
        int         exp_pops;
        int         exp_nack;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Expected engine traffic: START, every write up to and including the
    // first NACKed one, then STOP. err_op counts operations with START as 0.
    function automatic void build_model(input logic [6:0] a, input logic [7:0] c,
                                        input int len, input int eop);
        logic [7:0] wr[$];
        exp_i.delete();
        exp_b.delete();
        wr.push_back({a, 1'b0});
        wr.push_back(c);
        foreach (data_q[k]) wr.push_back(data_q[k]);
        m_pops = 0;
        m_nack = 1'b0;
        exp_i.push_back(2'd0);
        exp_b.push_back(8'h00);
        for (int k = 0; k < 2 + len; k++) begin
            exp_i.push_back(2'd3);
            exp_b.push_back(wr[k]);
            if (k >= 2) m_pops++;
            if (eop == k + 1) begin
                m_nack = 1'b1;
                break;
            end
        end
        exp_i.push_back(2'd1);
        exp_b.push_back(8'h00);
    endfunction

    // Upstream byte source, engine responder and protocol monitor
    initial begin
        bus.complete  = 1'b0;
        bus.error     = 1'b0;
        bus.dataValid = 1'b0;
        bus.dataIn    = 8'h00;
        eng_cnt = 0;
        eng_lat = 0;
        low_run = 100;
        forever begin
            @(negedge clk);
            bus.complete = 1'b0;
            bus.error    = 1'b0;
            if (rst) begin
                bus.dataValid = 1'b0;
                eng_cnt = 0;
                low_run = 100;
                continue;
            end
            if (!hold_valid && src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
                bus.dataValid = 1'b1;
                bus.dataIn    = src_q[0];
            end else begin
                bus.dataValid = 1'b0;
            end
            if (bus.dataReady) ready_seen = 1'b1;
            if (bus.dataValid && bus.dataReady) begin
                void'(src_q.pop_front());
                pops++;
            end
            if (bus.dataReady && bus.enable) viol++;
            if (bus.enable && bus.instruction == 2'd2) viol++;
            if (bus.done && !bus.busy) viol++;
            if (bus.enable) begin
                if (low_run > 0 && low_run < GAP) viol++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (bus.enable) begin
                if (eng_cnt >= eng_lat) begin
                    bus.complete = 1'b1;
                    bus.error    = (err_op_cur != 0 && op_idx == err_op_cur);
                    got_i.push_back(bus.instruction);
                    got_b.push_back(bus.byteToSend);
                    op_idx++;
                    eng_cnt = 0;
                    eng_lat = $urandom_range(0, lat_max);
                end else begin
                    eng_cnt++;
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_nack = bus.nack;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enable"},      bus.enable,      0);
        chk({tag, "_instruction"}, bus.instruction, 0);
        chk({tag, "_byteToSend"},  bus.byteToSend,  0);
        chk({tag, "_dataReady"},   bus.dataReady,   0);
        chk({tag, "_busy"},        bus.busy,        0);
        chk({tag, "_done"},        bus.done,        0);
        chk({tag, "_nack"},        bus.nack,        0);
    endtask

    task automatic start_txn(input logic [6:0] a, input logic [7:0] c, input logic [4:0] len,
                             input int eop, input logic [7:0] d0, input logic [7:0] d1);
        data_q.delete();
        for (int k = 0; k < int'(len); k++)
            data_q.push_back(k == 0 ? d0 : (k == 1 ? d1 : 8'($urandom)));
        build_model(a, c, int'(len), eop);
        got_i.delete();
        got_b.delete();
        src_q = data_q;
        pops = 0; done_cnt = 0; viol = 0; op_idx = 0; err_op_cur = eop;
        ready_seen = 1'b0;
        @(negedge clk);
        bus.txStart = 1'b1;
        bus.txAddr  = a;
        bus.txCtrl  = c;
        bus.txLen   = len;
        @(negedge clk);
        bus.txStart = 1'b0;
        bus.txAddr  = 7'($urandom);
        bus.txCtrl  = 8'($urandom);
        bus.txLen   = 5'($urandom);
    endtask

    task automatic finish_txn(input string tag, input int t_ops, input int t_pops, input int t_nack);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_timeout"}, (done_cnt == 0), 0);
        repeat (4) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_busy_after"}, bus.busy, 0);
        chk({tag, "_done_nack"}, done_nack, m_nack);
        chk({tag, "_nack_hold"}, bus.nack, m_nack);
        chk({tag, "_pops"}, pops, m_pops);
        chk({tag, "_ready_seen"}, ready_seen, (m_pops > 0));
        chk({tag, "_protocol_viol"}, viol, 0);
        chk({tag, "_op_count"}, got_i.size(), exp_i.size());
        if (t_ops >= 0) begin
            chk({tag, "_tbl_ops"}, got_i.size(), t_ops);
            chk({tag, "_tbl_pops"}, pops, t_pops);
            chk({tag, "_tbl_nack"}, bus.nack, t_nack);
        end
        for (int k = 0; k < exp_i.size() && k < got_i.size(); k++) begin
            chk($sformatf("%s_op%0d_instr", tag, k), got_i[k], exp_i[k]);
            if (exp_i[k] == 2'd3)
                chk($sformatf("%s_op%0d_byte", tag, k), got_b[k], exp_b[k]);
        end
    endtask

    task automatic run_txn(input string tag, input logic [6:0] a, input logic [7:0] c,
                           input logic [4:0] len, input int eop, input logic [7:0] d0,
                           input logic [7:0] d1, input bit poke, input int t_ops,
                           input int t_pops, input int t_nack);
        start_txn(a, c, len, eop, d0, d1);
        chk({tag, "_busy_after_accept"}, bus.busy, 1);
        chk({tag, "_nack_cleared"}, bus.nack, 0);
        if (poke) begin
            repeat (3) @(negedge clk);
            bus.txStart = 1'b1;
            bus.txAddr  = ~a;
            bus.txCtrl  = ~c;
            bus.txLen   = ~len;
            @(negedge clk);
            bus.txStart = 1'b0;
        end
        finish_txn(tag, t_ops, t_pops, t_nack);
    endtask

    vec_t tbl[7];

    initial begin
        int n, bad, stops;
        logic [6:0] ra;
        logic [7:0] rc;
        logic [4:0] rl;
        int re;

        tbl[0] = '{7'h3C, 8'h40, 5'd2,  0, 8'hAA, 8'h55, 1'b0, 6,  2,  0};
        tbl[1] = '{7'h3C, 8'h00, 5'd0,  0, 8'h00, 8'h00, 1'b0, 4,  0,  0};
        tbl[2] = '{7'h3C, 8'h40, 5'd3,  1, 8'h11, 8'h22, 1'b0, 3,  0,  1};
        tbl[3] = '{7'h12, 8'h34, 5'd3,  2, 8'h33, 8'h44, 1'b0, 4,  0,  1};
        tbl[4] = '{7'h7F, 8'hFF, 5'd4,  4, 8'h5A, 8'hA5, 1'b1, 6,  2,  1};
        tbl[5] = '{7'h00, 8'h00, 5'd31, 0, 8'h01, 8'h02, 1'b0, 35, 31, 0};
        tbl[6] = '{7'h55, 8'hAA, 5'd1,  3, 8'hC3, 8'h00, 1'b0, 5,  1,  1};

        rst = 1'b1;
        bus.txStart = 1'b0;
        bus.txAddr  = '0;
        bus.txCtrl  = '0;
        bus.txLen   = '0;
        hold_valid  = 1'b0;
        valid_pct   = 100;
        lat_max     = 1;
        err_op_cur  = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            lat_max   = i % 3;
            valid_pct = 70;
            run_txn($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].ctrl, tbl[i].len,
                    tbl[i].err_op, tbl[i].d0, tbl[i].d1, tbl[i].poke,
                    tbl[i].exp_ops, tbl[i].exp_pops, tbl[i].exp_nack);
        end

        // FETCH stall: no valid data for 50 cycles
        lat_max = 1;
        valid_pct = 100;
        hold_valid = 1'b1;
        start_txn(7'h21, 8'h07, 5'd2, 0, 8'hDE, 8'hAD);
        n = 0;
        while (!bus.dataReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_fetch", bus.dataReady, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!(bus.dataReady && !bus.enable)) bad++;
        end
        chk("stall_hold", bad, 0);
        chk("stall_no_pop", pops, 0);
        hold_valid = 1'b0;
        finish_txn("stall", 6, 2, 0);

        // Reset while the control byte is being written
        lat_max = 3;
        start_txn(7'h3C, 8'h40, 5'd2, 0, 8'hAA, 8'h55);
        n = 0;
        while (!(bus.enable && bus.instruction == 2'd3 && bus.byteToSend == 8'h40) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_ctrl", bus.byteToSend, 8'h40);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        stops = 0;
        foreach (got_i[k]) if (got_i[k] == 2'd1) stops++;
        chk("midrst_no_stop", stops, 0);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", bus.busy, 0);
        src_q.delete();
        run_txn("post_rst", 7'h3C, 8'h40, 5'd2, 0, 8'hAA, 8'h55, 1'b0, 6, 2, 0);

        // Randomized transactions against the model
        for (int t = 0; t < 25; t++) begin
            ra = 7'($urandom);
            rc = 8'($urandom);
            rl = 5'($urandom_range(0, 6));
            re = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + int'(rl)) : 0;
            lat_max   = $urandom_range(0, 3);
            valid_pct = $urandom_range(30, 100);
            run_txn($sformatf("rnd%0d", t), ra, rc, rl, re, 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 4) == 0), -1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
